// File: rtl/tnn_feature_feeder_if.sv
// Handshake bundle between the feature source, the feeder and the result consumer.
// The feeder takes the slave view; the environment driving features and taking results takes the master view.
interface tnn_feature_feeder_if #(
    parameter int FEAT_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic              m_class;
    logic              m_err;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
endinterface

// File: rtl/tnn_feature_feeder.sv
// Quantizes raw features to 2 bits, frames four of them onto the TNN core inputs,
// captures the core decision and hands it off on a valid/ready port with a framing flag.
//
// state      | meaning
// COLLECT    | accepting beats, writing quantized value to cls_[idx]
// EVAL       | one cycle with cls_* stable; core decision captured
// OUTPUT     | result presented, waiting for m_ready
// DROP       | discarding the tail of a long frame up to its s_last
module tnn_feature_feeder #(
    parameter int FEAT_W = 8,
    parameter int TH0    = 64,
    parameter int TH1    = 128,
    parameter int TH2    = 192,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    tnn_feature_feeder_if.slave bus,
    output logic [1:0]         cls_a_o,
    output logic [1:0]         cls_b_o,
    output logic [1:0]         cls_c_o,
    output logic [1:0]         cls_d_o,
    input  logic               cls_out_i,
    output logic [CNT_W-1:0]   res_cnt_o
);
    generate
        if (!(TH0 < TH1 && TH1 < TH2)) begin : g_bad_th
            $error("tnn_feature_feeder: thresholds must satisfy TH0 < TH1 < TH2");
        end
    endgenerate

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_EVAL    = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    localparam logic [FEAT_W-1:0] TH0_C = FEAT_W'(TH0);
    localparam logic [FEAT_W-1:0] TH1_C = FEAT_W'(TH1);
    localparam logic [FEAT_W-1:0] TH2_C = FEAT_W'(TH2);

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic             long_q, long_d;
    logic [3:0][1:0]  cls_q, cls_d;
    logic             m_class_q, m_class_d;
    logic             m_err_q, m_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [1:0]       q_beat;

    assign bus.s_ready = (state_q == ST_COLLECT) || (state_q == ST_DROP);
    assign bus.m_valid = (state_q == ST_OUTPUT);
    assign bus.m_class = m_class_q;
    assign bus.m_err   = m_err_q;
    assign cls_a_o     = cls_q[0];
    assign cls_b_o     = cls_q[1];
    assign cls_c_o     = cls_q[2];
    assign cls_d_o     = cls_q[3];
    assign res_cnt_o   = cnt_q;

    assign accept = bus.s_valid & bus.s_ready;

    always_comb begin
        if (bus.s_data >= TH2_C)      q_beat = 2'd3;
        else if (bus.s_data >= TH1_C) q_beat = 2'd2;
        else if (bus.s_data >= TH0_C) q_beat = 2'd1;
        else                          q_beat = 2'd0;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        long_d    = long_q;
        cls_d     = cls_q;
        m_class_d = m_class_q;
        m_err_d   = m_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    cls_d[idx_q] = q_beat;
                    if (idx_q != 2'd3) begin
                        if (bus.s_last) begin
                            // Short frame skips evaluation: the core inputs are incomplete.
                            err_d     = 1'b1;
                            m_class_d = 1'b0;
                            m_err_d   = 1'b1;
                            state_d   = ST_OUTPUT;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        err_d   = ~bus.s_last;
                        long_d  = ~bus.s_last;
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_EVAL: begin
                m_class_d = cls_out_i;
                m_err_d   = err_q;
                state_d   = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.m_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    idx_d   = 2'd0;
                    long_d  = 1'b0;
                    state_d = long_q ? ST_DROP : ST_COLLECT;
                end
            end
            default: begin
                if (accept && bus.s_last) state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            idx_q     <= 2'd0;
            err_q     <= 1'b0;
            long_q    <= 1'b0;
            cls_q     <= '0;
            m_class_q <= 1'b0;
            m_err_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            long_q    <= long_d;
            cls_q     <= cls_d;
            m_class_q <= m_class_d;
            m_err_q   <= m_err_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
